// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the imem request/valid handshake and the IF/ID register,
// converts redirects into bubbles and waits out responses made stale by a redirect.
module fetch_unit #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP       = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] flush_addr,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        fetch_wait
);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } ifid_t;

    state_t      state, state_n;
    logic [31:0] addr_q, addr_n;
    logic [31:0] redirect_q, redirect_n;
    ifid_t       ifid_q, ifid_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            addr_q     <= BOOT_ADDR;
            redirect_q <= 32'h0;
            ifid_q     <= '{instr: NOP, pc: 32'h0, valid: 1'b0};
        end else begin
            state      <= state_n;
            addr_q     <= addr_n;
            redirect_q <= redirect_n;
            ifid_q     <= ifid_n;
        end
    end

    always_comb begin
        state_n    = state;
        addr_n     = addr_q;
        redirect_n = redirect_q;
        ifid_n     = ifid_q;
        case (state)
            IDLE: begin
                state_n = REQ;
                if (flush) addr_n = flush_addr;
            end
            REQ: begin
                if (imem_valid) begin
                    if (flush) begin
                        addr_n = flush_addr;
                        ifid_n = '{instr: NOP, pc: addr_q, valid: 1'b0};
                    end else if (!stall) begin
                        addr_n = addr_q + 32'd4;
                        ifid_n = '{instr: imem_rdata, pc: addr_q, valid: 1'b1};
                    end
                end else begin
                    // The request stays outstanding, so addr_q must not move until it completes.
                    if (flush) begin
                        redirect_n = flush_addr;
                        ifid_n     = '{instr: NOP, pc: addr_q, valid: 1'b0};
                        state_n    = DROP;
                    end else if (!stall) begin
                        ifid_n.instr = NOP;
                        ifid_n.valid = 1'b0;
                    end
                end
            end
            DROP: begin
                if (flush) redirect_n = flush_addr;
                if (imem_valid) begin
                    addr_n  = flush ? flush_addr : redirect_q;
                    state_n = REQ;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign imem_req    = (state == REQ) || (state == DROP);
    assign imem_addr   = addr_q;
    assign fetch_wait  = !((state == REQ) && imem_valid && !flush && !stall);
    assign instr_out   = ifid_q.instr;
    assign instr_pc    = ifid_q.pc;
    assign instr_valid = ifid_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a wait-state memory model feeds the DUT and a monitor
// compares every newly accepted instruction against expectations queued by each test.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] XK  = 32'hA5A5_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_addr = 32'h0;
    logic        stall = 1'b0;
    logic        imem_req, imem_valid, instr_valid, fetch_wait;
    logic [31:0] imem_addr, imem_rdata, instr_out, instr_pc;

    logic        rst2 = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] zero32 = 32'h0;
    logic        req2, v2, fw2;
    logic [31:0] addr2, rdata2, out2, pc2;

    int   checks = 0;
    int   errors = 0;
    int   ws = 0;
    int   wait_cnt;
    logic stall_d = 1'b0;
    logic mon_en = 1'b0;
    exp_t q[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_addr(flush_addr), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
        .imem_rdata(imem_rdata), .instr_out(instr_out), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .fetch_wait(fetch_wait)
    );

    fetch_unit #(.BOOT_ADDR(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst2), .flush(zero), .flush_addr(zero32), .stall(zero),
        .imem_req(req2), .imem_addr(addr2), .imem_valid(req2),
        .imem_rdata(rdata2), .instr_out(out2), .instr_pc(pc2),
        .instr_valid(v2), .fetch_wait(fw2)
    );

    // Memory model: answers after ws wait cycles of a held request.
    assign imem_valid = imem_req && (wait_cnt >= ws);
    assign imem_rdata = imem_addr ^ XK;
    assign rdata2     = addr2 ^ XK;

    always @(posedge clk or negedge rst) begin
        if (!rst) wait_cnt <= 0;
        else if (!imem_req || imem_valid) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    always @(posedge clk) stall_d <= stall;

    // Monitor: IF/ID content is new unless the preceding edge was stalled.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en && rst) begin
            if (instr_valid && !stall_d) begin
                if (q.size() != 0) begin
                    e = q.pop_front();
                    checks++;
                    if (instr_pc !== e.pc || instr_out !== e.ins) begin
                        errors++;
                        $display("FAIL sb_instr: got pc=%h instr=%h, expected pc=%h instr=%h",
                                 instr_pc, instr_out, e.pc, e.ins);
                    end
                end
            end else if (!instr_valid) begin
                checks++;
                if (instr_out !== NOP) begin
                    errors++;
                    $display("FAIL bubble_nop: instr_out=%h expected %h", instr_out, NOP);
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc  = pc;
        e.ins = pc ^ XK;
        q.push_back(e);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst = 1'b0; flush = 1'b0; stall = 1'b0; flush_addr = 32'h0; ws = 0;
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 50 && q.size() != 0; n++) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected instructions never arrived, required 0", name, q.size());
        end
    endtask

    task automatic wait_addr(input logic [31:0] a);
        int n;
        for (n = 0; n < 50 && imem_addr !== a; n++) @(negedge clk);
        checks++;
        if (imem_addr !== a) begin
            errors++;
            $display("FAIL wait_addr: imem_addr=%h never reached %h", imem_addr, a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || fetch_wait !== 1'b1 || imem_addr !== 32'h0 ||
            instr_out !== NOP || instr_pc !== 32'h0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals: req=%b wait=%b addr=%h out=%h pc=%h v=%b, expected 0 1 0 %h 0 0",
                     imem_req, fetch_wait, imem_addr, instr_out, instr_pc, instr_valid, NOP);
        end
    endtask

    task automatic test_zero_wait();
        do_reset();
        for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_wait !== 1'b0) begin
            errors++;
            $display("FAIL zw_first_req: v=%b req=%b addr=%h wait=%b, expected 0 1 0 0",
                     instr_valid, imem_req, imem_addr, fetch_wait);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'(i * 4)) begin
                errors++;
                $display("FAIL zw_seq%0d: v=%b pc=%h, expected 1 %h", i, instr_valid, instr_pc, i * 4);
            end
        end
        drain("zw");
    endtask

    task automatic test_wait_states();
        do_reset();
        ws = 2;
        push_exp(32'h0);
        push_exp(32'h4);
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'(i * 4) || fetch_wait !== (k != 2) ||
                    instr_valid !== (i > 0 && k == 0)) begin
                    errors++;
                    $display("FAIL ws_i%0d_k%0d: req=%b addr=%h wait=%b v=%b, expected 1 %h %b %b",
                             i, k, imem_req, imem_addr, fetch_wait, instr_valid,
                             i * 4, k != 2, i > 0 && k == 0);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h4) begin
            errors++;
            $display("FAIL ws_second: v=%b pc=%h, expected 1 00000004", instr_valid, instr_pc);
        end
        drain("ws");
    endtask

    task automatic test_flush_valid();
        do_reset();
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h100); push_exp(32'h104);
        wait_addr(32'h8);
        flush = 1'b1; flush_addr = 32'h100;
        #1;
        checks++;
        if (fetch_wait !== 1'b1) begin
            errors++;
            $display("FAIL fv_wait: fetch_wait=%b expected 1", fetch_wait);
        end
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || instr_pc !== 32'h8 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL fv_bubble: v=%b pc=%h addr=%h, expected 0 00000008 00000100",
                     instr_valid, instr_pc, imem_addr);
        end
        drain("fv");
    endtask

    task automatic test_flush_drop();
        do_reset();
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
        push_exp(32'h300); push_exp(32'h304);
        wait_addr(32'h10);
        ws = 100;
        flush = 1'b1; flush_addr = 32'h200;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_valid !== 1'b0 || instr_pc !== 32'h10) begin
            errors++;
            $display("FAIL fd_drop: req=%b addr=%h v=%b pc=%h, expected 1 00000010 0 00000010",
                     imem_req, imem_addr, instr_valid, instr_pc);
        end
        flush_addr = 32'h300;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_addr !== 32'h10 || fetch_wait !== 1'b1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL fd_hold: addr=%h wait=%b v=%b, expected 00000010 1 0",
                     imem_addr, fetch_wait, instr_valid);
        end
        ws = 0;
        @(negedge clk);
        checks++;
        if (imem_addr !== 32'h300 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL fd_target: addr=%h v=%b, expected 00000300 0", imem_addr, instr_valid);
        end
        drain("fd");
    endtask

    task automatic test_stall();
        do_reset();
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
        wait_addr(32'h8);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (instr_pc !== 32'h4 || instr_valid !== 1'b1 || imem_addr !== 32'h8 ||
                fetch_wait !== 1'b1 || instr_out !== (32'h4 ^ XK)) begin
                errors++;
                $display("FAIL st_hold%0d: pc=%h v=%b addr=%h wait=%b out=%h, expected 00000004 1 00000008 1 %h",
                         k, instr_pc, instr_valid, imem_addr, fetch_wait, instr_out, 32'h4 ^ XK);
            end
        end
        stall = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_pc !== 32'h8 || instr_valid !== 1'b1 || imem_addr !== 32'hC) begin
            errors++;
            $display("FAIL st_release: pc=%h v=%b addr=%h, expected 00000008 1 0000000c",
                     instr_pc, instr_valid, imem_addr);
        end
        drain("st");
    endtask

    task automatic test_reset_mid();
        do_reset();
        wait_addr(32'h8);
        ws = 100;
        repeat (2) @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || instr_pc !== 32'h4 || imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL rm_pre: req=%b pc=%h addr=%h, expected 1 00000004 00000008",
                     imem_req, instr_pc, imem_addr);
        end
        mon_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || fetch_wait !== 1'b1 || imem_addr !== 32'h0 ||
            instr_out !== NOP || instr_pc !== 32'h0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL rm_async: req=%b wait=%b addr=%h out=%h pc=%h v=%b, expected 0 1 0 %h 0 0",
                     imem_req, fetch_wait, imem_addr, instr_out, instr_pc, instr_valid, NOP);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] pcs [3];
        pcs[0] = 32'hFFFF_FFF8; pcs[1] = 32'hFFFF_FFFC; pcs[2] = 32'h0;
        @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        checks++;
        if (v2 !== 1'b0 || addr2 !== 32'hFFFF_FFF8 || req2 !== 1'b1) begin
            errors++;
            $display("FAIL wr_first: v=%b addr=%h req=%b, expected 0 fffffff8 1", v2, addr2, req2);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (v2 !== 1'b1 || pc2 !== pcs[i] || out2 !== (pcs[i] ^ XK)) begin
                errors++;
                $display("FAIL wr_seq%0d: v=%b pc=%h out=%h, expected 1 %h %h",
                         i, v2, pc2, out2, pcs[i], pcs[i] ^ XK);
            end
        end
        checks++;
        if (addr2 !== 32'h4) begin
            errors++;
            $display("FAIL wr_addr: addr=%h expected 00000004", addr2);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_flush_valid();
        test_flush_drop();
        test_stall();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 2-stage RV32I pipeline. It sits between the program-counter / redirect logic and decode. It owns the instruction-memory request/valid handshake and the IF/ID pipeline register. It also turns branch/jump redirects into bubbles and discards any instruction-memory response that a redirect has made stale. It holds the IF/ID contents while a load is waiting on data memory.

## Interface
Parameters:
- BOOT_ADDR, 32'h0000_0000, first fetch address after reset
- NOP, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  redirect (taken branch / jal / jalr) resolved this cycle
- flush_addr  in  32  redirect target, valid when flush=1
- stall  in  1  load waiting on dmem (load && !dmem_valid); freeze IF/ID
- imem_req  out  1  instruction-memory request
- imem_addr  out  32  request address, equals internal addr_q
- imem_valid  in  1  response valid; only meaningful while imem_req=1
- imem_rdata  in  32  instruction word, valid with imem_valid
- instr_out  out  32  IF/ID instruction
- instr_pc  out  32  IF/ID instruction address
- instr_valid  out  1  IF/ID holds a real instruction (0 = bubble)
- fetch_wait  out  1  high when no instruction is accepted this cycle; used by the hazard/PC logic

## Operation
- Registers:
  - state ∈ {IDLE, REQ, DROP}
  - addr_q[31:0], the current or next fetch address
  - redirect_q[31:0], the pending target while in DROP
  - IF/ID registers: instr_out, instr_pc, instr_valid
- Output decode:
  - imem_req = (state==REQ) | (state==DROP).
  - imem_addr = addr_q in every state.
  - fetch_wait = !(state==REQ & imem_valid & !flush & !stall).
- IDLE (after reset only):
  - imem_req = 0. Next state is REQ.
  - If flush is high: addr_q <= flush_addr.
- REQ, imem_valid=1:
  - If flush: drop the response. addr_q <= flush_addr. IF/ID <= {NOP, addr_q, 0}. Stay in REQ.
  - Else if stall: drop the response. Hold IF/ID. Hold addr_q, so the same address is re-fetched. Stay in REQ.
  - Else: accept. IF/ID <= {imem_rdata, addr_q, 1}. addr_q <= addr_q + 4, taken mod 2^32 (0xFFFF_FFFC wraps to 0).
- REQ, imem_valid=0:
  - If flush: redirect_q <= flush_addr. IF/ID <= {NOP, addr_q, 0}. Go to DROP. addr_q stays unchanged because the request is still outstanding.
  - Else if stall: hold IF/ID.
  - Else: IF/ID <= {NOP, instr_pc, 0} (bubble).
- DROP (waiting out a stale request):
  - imem_addr stays equal to the stale addr_q. IF/ID stays a bubble.
  - A further flush overwrites redirect_q; the latest target wins.
  - On imem_valid: discard the data. addr_q <= (flush ? flush_addr : redirect_q). Go to REQ.
- Priority: flush > stall > accept/bubble.

## Timing
- Reset (asynchronous, any state, including mid-request):
  - state = IDLE, addr_q = BOOT_ADDR, redirect_q = 0.
  - instr_out = NOP, instr_pc = 0, instr_valid = 0.
  - imem_req = 0, fetch_wait = 1.
  - Any outstanding memory response after reset is ignored, because imem_req=0 in IDLE.
- Handshake rules:
  - imem_req stays high and imem_addr stays stable from request start until the cycle in which imem_valid=1.
  - A new request may start in the very next cycle.
  - Zero-wait memory (imem_valid in the same cycle as the address) gives a throughput of 1 instruction/cycle.
- Latency: an accepted word appears on instr_out the cycle after the edge at which imem_valid was sampled.
- First fetch: rst released before edge 0, then IDLE at edge 0. The first request is driven after edge 0. With zero-wait memory, the first instruction is visible after edge 1.
- A flush always produces at least one bubble. No word fetched from a pre-flush address ever reaches instr_valid=1.

## Test plan
- Reset + zero-wait memory (rdata = addr ^ 0xA5A5_0000) → instr_pc sequence 0,4,8,C on consecutive cycles; first instr_valid=1 one cycle after the IDLE cycle; instr_out matches rdata.
- Memory with 2 wait states → imem_addr held stable for 3 cycles; fetch_wait=1 for 2 cycles; two bubbles (instr_valid=0, instr_out=NOP) between instructions.
- flush with flush_addr=0x100 in the same cycle as imem_valid for address 0x8 → next instr_valid=1 has instr_pc=0x100; 0x8 is never issued as valid.
- flush (flush_addr=0x200) while a request to 0x10 is pending; second flush (flush_addr=0x300) in DROP; response arrives → stale data dropped; next request addr=0x300.
- stall held 3 cycles while memory is valid → IF/ID unchanged; imem_addr unchanged; after release the same address is accepted exactly once.
- Start at BOOT_ADDR=0xFFFF_FFF8 → pc sequence FFFF_FFF8, FFFF_FFFC, 0. rst asserted mid-wait → all outputs return to their reset values immediately.
